// File: rtl/vga_sync_receiver.sv
`timescale 1ns/1ps
// vga_sync_receiver: recovers pixel coordinates from incoming hsync/vsync/de,
// checks line/frame timing against the expected raster, and reports lock and errors.
// Latency: 3 pix_en ticks from pin to de_out/x_out/y_out/line_start/frame_start.
// Backpressure: none; this block only observes the video stream.
// Ports:
//   clk_50MHz, reset (async, active-high), pix_en (pixel tick qualifier)
//   hsync_in, vsync_in, de_in        : asynchronous video timing inputs
//   x_out, y_out, de_out             : recovered coordinates and registered display enable
//   line_start, frame_start          : one-cycle pulses on hsync/vsync leading edges
//   locked, timing_err, err_count    : lock status, violation pulse, saturating error count
module vga_sync_receiver #(
  parameter int H_TOTAL          = 800,
  parameter int H_SYNC           = 96,
  parameter int V_TOTAL          = 525,
  parameter int LOCK_FRAMES      = 2,
  parameter bit SYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       de_in,
  output logic [9:0] x_out,
  output logic [9:0] y_out,
  output logic       de_out,
  output logic       line_start,
  output logic       frame_start,
  output logic       locked,
  output logic       timing_err,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic        SYNC_INV   = (SYNC_ACTIVE_HIGH == 1'b0);
  localparam logic [11:0] LINE_EXP   = 12'(H_TOTAL);
  localparam logic [10:0] HWID_EXP   = 11'(H_SYNC);
  localparam logic [9:0]  LINES_EXP  = 10'(V_TOTAL);
  // hcnt value on the tick where it would step to 2*H_TOTAL
  localparam logic [10:0] TMO_LAST   = 11'(2 * H_TOTAL - 1);
  localparam logic [8:0]  LOCK_GOAL  = 9'(LOCK_FRAMES);

  // Bit order in the synchronizer vectors: {de, vsync, hsync}
  logic [2:0]  sync1_q, sync1_d;
  logic [2:0]  sync2_q, sync2_d;
  logic [2:0]  prev_q, prev_d;
  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] hwid_q, hwid_d;
  logic [9:0]  lines_q, lines_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        de_q, de_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic        locked_q, locked_d;
  logic        timing_err_q, timing_err_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [7:0]  good_q, good_d;
  state_t      state_q, state_d;

  logic [2:0]  norm;
  logic        h_lead, h_trail, v_lead, de_rise, de_fall;
  logic [11:0] line_len;
  logic [9:0]  lines_inc;
  logic [8:0]  good_inc;
  logic        len_err, wid_err, frame_err, timeout, any_viol;
  logic        err_pulse;

  // Only the syncs are polarity-normalized; de is always active-high.
  assign norm     = sync2_q ^ {1'b0, SYNC_INV, SYNC_INV};

  assign h_lead   = pix_en &  norm[0] & ~prev_q[0];
  assign h_trail  = pix_en & ~norm[0] &  prev_q[0];
  assign v_lead   = pix_en &  norm[1] & ~prev_q[1];
  assign de_rise  = pix_en &  norm[2] & ~prev_q[2];
  assign de_fall  = pix_en & ~norm[2] &  prev_q[2];

  // Widened so a saturated hcnt of 2047 still yields a distinct length.
  assign line_len = {1'b0, hcnt_q} + 12'd1;
  // Line closes before frame processing, so a coincident hsync edge is counted.
  assign lines_inc = (h_lead && (lines_q != '1)) ? lines_q + 10'd1 : lines_q;
  assign good_inc  = {1'b0, good_q} + 9'd1;

  assign len_err   = h_lead  & (line_len  != LINE_EXP);
  assign wid_err   = h_trail & (hwid_q    != HWID_EXP);
  assign frame_err = v_lead  & (lines_inc != LINES_EXP);
  assign timeout   = pix_en & ~h_lead & (hcnt_q == TMO_LAST);
  assign any_viol  = len_err | wid_err | frame_err | timeout;

  // Datapath next-state
  always_comb begin
    sync1_d       = sync1_q;
    sync2_d       = sync2_q;
    prev_d        = prev_q;
    hcnt_d        = hcnt_q;
    hwid_d        = hwid_q;
    lines_d       = lines_q;
    x_d           = x_q;
    y_d           = y_q;
    de_d          = de_q;
    line_start_d  = h_lead;
    frame_start_d = v_lead;

    if (pix_en) begin
      sync1_d = {de_in, vsync_in, hsync_in};
      sync2_d = sync1_q;
      prev_d  = norm;
      de_d    = norm[2];

      if (h_lead) begin
        hcnt_d = '0;
      end else if (hcnt_q != '1) begin
        hcnt_d = hcnt_q + 11'd1;
      end

      // The leading-edge tick is the first active tick of the pulse.
      if (norm[0]) begin
        if (h_lead) begin
          hwid_d = 11'd1;
        end else if (hwid_q != '1) begin
          hwid_d = hwid_q + 11'd1;
        end
      end

      lines_d = v_lead ? '0 : lines_inc;

      if (de_rise) begin
        x_d = '0;
      end else if (norm[2]) begin
        if (x_q != '1) begin
          x_d = x_q + 10'd1;
        end
      end else begin
        x_d = '0;
      end

      if (v_lead) begin
        y_d = '0;
      end else if (de_fall && (y_q != '1)) begin
        y_d = y_q + 10'd1;
      end
    end
  end

  // Lock FSM
  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    err_pulse = 1'b0;

    case (state_q)
      ST_SEARCH: begin
        if (v_lead) begin
          state_d = ST_VERIFY;
          good_d  = '0;
        end
      end
      ST_VERIFY: begin
        if (any_viol) begin
          err_pulse = 1'b1;
          state_d   = ST_SEARCH;
          good_d    = '0;
        end else if (v_lead) begin
          good_d = good_inc[7:0];
          if (good_inc >= LOCK_GOAL) begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (any_viol) begin
          err_pulse = 1'b1;
          state_d   = ST_SEARCH;
          good_d    = '0;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        good_d  = '0;
      end
    endcase

    // Registered from the next state so locked moves on the same edge as
    // frame_start / timing_err.
    locked_d     = (state_d == ST_LOCKED);
    timing_err_d = err_pulse;
    err_count_d  = (err_pulse && (err_count_q != '1)) ? err_count_q + 8'd1 : err_count_q;
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      prev_q        <= '0;
      hcnt_q        <= '0;
      hwid_q        <= '0;
      lines_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      timing_err_q  <= 1'b0;
      err_count_q   <= '0;
      good_q        <= '0;
      state_q       <= ST_SEARCH;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      hcnt_q        <= hcnt_d;
      hwid_q        <= hwid_d;
      lines_q       <= lines_d;
      x_q           <= x_d;
      y_q           <= y_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      timing_err_q  <= timing_err_d;
      err_count_q   <= err_count_d;
      good_q        <= good_d;
      state_q       <= state_d;
    end
  end

  assign x_out       = x_q;
  assign y_out       = y_q;
  assign de_out      = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign timing_err  = timing_err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
`timescale 1ns/1ps
// Bench for vga_sync_receiver on a reduced raster: 40 ticks/line (6-tick hsync),
// 20 lines/frame (2-line vsync), active window 24x12 at h=10..33, v=4..15.
module tb_vga_sync_receiver;
  localparam int HT = 40;
  localparam int HS = 6;
  localparam int VT = 20;
  localparam int LF = 2;
  localparam int NV = 11;

  logic       clk_50MHz = 1'b0;
  logic       reset = 1'b1;
  logic       pix_en = 1'b0;
  logic       hsync_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic       de_in = 1'b0;
  logic [9:0] x_out, y_out;
  logic       de_out, line_start, frame_start, locked, timing_err;
  logic [7:0] err_count;

  vga_sync_receiver #(
    .H_TOTAL(HT), .H_SYNC(HS), .V_TOTAL(VT), .LOCK_FRAMES(LF), .SYNC_ACTIVE_HIGH(1'b1)
  ) dut (
    .clk_50MHz(clk_50MHz), .reset(reset), .pix_en(pix_en),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
    .x_out(x_out), .y_out(y_out), .de_out(de_out),
    .line_start(line_start), .frame_start(frame_start),
    .locked(locked), .timing_err(timing_err), .err_count(err_count)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  typedef struct {
    int         v;
    int         h;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
    logic       lk;
  } vec_t;

  vec_t tab [NV];

  int   n_chk = 0;
  int   n_fail = 0;
  bit   half = 1'b0;
  bit   tab_en = 1'b0;
  int   tab_hits = 0;
  int   n_terr = 0;
  int   terr0 = 0;
  int   hv0 = -1, hh0 = -1, hv1 = -1, hh1 = -1;
  logic prev_locked = 1'b0;
  logic fs_lock [$];
  logic fs_prev [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic logic de_f(input int v, input int h);
    return (v >= 4) && (v < 16) && (h >= 10) && (h < 34);
  endfunction

  // Outputs sampled after a tick's edge reflect the pin position of two ticks earlier.
  task automatic monitor();
    if (timing_err) n_terr++;
    if (frame_start) begin
      fs_lock.push_back(locked);
      fs_prev.push_back(prev_locked);
    end
    prev_locked = locked;
    if (tab_en) begin
      for (int i = 0; i < NV; i++) begin
        if (tab[i].v == hv1 && tab[i].h == hh1) begin
          tab_hits++;
          n_chk++;
          if ({de_out, x_out, y_out, line_start, frame_start, locked} !==
              {tab[i].de, tab[i].x, tab[i].y, tab[i].ls, tab[i].fs, tab[i].lk}) begin
            n_fail++;
            $display("FAIL vec%0d (v=%0d,h=%0d): got de=%0b x=%0d y=%0d ls=%0b fs=%0b lk=%0b, expected de=%0b x=%0d y=%0d ls=%0b fs=%0b lk=%0b",
                     i, hv1, hh1, de_out, x_out, y_out, line_start, frame_start, locked,
                     tab[i].de, tab[i].x, tab[i].y, tab[i].ls, tab[i].fs, tab[i].lk);
          end
        end
      end
    end
  endtask

  task automatic step(input logic h, input logic v, input logic d, input int pv, input int ph);
    hsync_in = h;
    vsync_in = v;
    de_in    = d;
    pix_en   = 1'b1;
    @(posedge clk_50MHz);
    #1;
    monitor();
    hv1 = hv0; hh1 = hh0;
    hv0 = pv;  hh0 = ph;
    if (half) begin
      pix_en = 1'b0;
      @(posedge clk_50MHz);
      #1;
      check("idle_no_pulse", {29'd0, line_start, frame_start, timing_err}, 32'd0);
    end
  endtask

  task automatic run_lines(input int v_from, input int v_to, input int extra_line, input int hole_after);
    for (int v = v_from; v < v_to; v++) begin
      for (int h = 0; h < HT; h++) step(h < HS, v < 2, de_f(v, h), v, h);
      if (v == extra_line) step(1'b0, 1'b0, 1'b0, -1, -1);
      if (v == hole_after) for (int k = 0; k < 2 * HT; k++) step(1'b0, 1'b0, 1'b0, -1, -1);
    end
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_async_zero",
          {x_out, y_out, de_out, line_start, frame_start, locked, timing_err, err_count},
          32'd0);
    #2 reset = 1'b0;
    hv0 = -1; hh0 = -1; hv1 = -1; hh1 = -1;
  endtask

  task automatic clear_fs();
    fs_lock.delete();
    fs_prev.delete();
  endtask

  // Three frame_start pulses: not locked, not locked, then locked rising with the third.
  task automatic check_lock_seq(input string name);
    check({name, "_fs_count"}, fs_lock.size(), 32'd3);
    while (fs_lock.size() < 3) begin
      fs_lock.push_back(1'bx);
      fs_prev.push_back(1'bx);
    end
    check({name, "_fs1_locked"}, {31'd0, fs_lock[0]}, 32'd0);
    check({name, "_fs2_locked"}, {31'd0, fs_lock[1]}, 32'd0);
    check({name, "_fs3_locked"}, {31'd0, fs_lock[2]}, 32'd1);
    check({name, "_fs3_prev_locked"}, {31'd0, fs_prev[2]}, 32'd0);
  endtask

  initial begin
    tab[0]  = '{0,  0,  1'b0, 10'd0,  10'd0,  1'b1, 1'b1, 1'b1};
    tab[1]  = '{0,  1,  1'b0, 10'd0,  10'd0,  1'b0, 1'b0, 1'b1};
    tab[2]  = '{1,  0,  1'b0, 10'd0,  10'd0,  1'b1, 1'b0, 1'b1};
    tab[3]  = '{4,  10, 1'b1, 10'd0,  10'd0,  1'b0, 1'b0, 1'b1};
    tab[4]  = '{4,  33, 1'b1, 10'd23, 10'd0,  1'b0, 1'b0, 1'b1};
    tab[5]  = '{4,  34, 1'b0, 10'd0,  10'd1,  1'b0, 1'b0, 1'b1};
    tab[6]  = '{5,  0,  1'b0, 10'd0,  10'd1,  1'b1, 1'b0, 1'b1};
    tab[7]  = '{9,  20, 1'b1, 10'd10, 10'd5,  1'b0, 1'b0, 1'b1};
    tab[8]  = '{15, 33, 1'b1, 10'd23, 10'd11, 1'b0, 1'b0, 1'b1};
    tab[9]  = '{15, 34, 1'b0, 10'd0,  10'd12, 1'b0, 1'b0, 1'b1};
    tab[10] = '{19, 37, 1'b0, 10'd0,  10'd12, 1'b0, 1'b0, 1'b1};

    // Reset state
    #25;
    check("reset_state",
          {x_out, y_out, de_out, line_start, frame_start, locked, timing_err, err_count},
          32'd0);
    reset = 1'b0;

    // Nominal timing: lock on third frame_start
    clear_fs();
    for (int f = 0; f < 3; f++) run_lines(0, VT, -1, -1);
    check_lock_seq("nominal");
    check("nominal_no_terr", n_terr, 32'd0);

    // Recovered coordinates while locked
    tab_en = 1'b1; tab_hits = 0;
    run_lines(0, VT, -1, -1);
    tab_en = 1'b0;
    check("coord_vec_hits", tab_hits, NV);
    check("coord_err_count", {24'd0, err_count}, 32'd0);

    // Reset mid-line while locked, then relock from a fresh SEARCH
    run_lines(0, 9, -1, -1);
    for (int h = 0; h < 20; h++) step(h < HS, 1'b0, de_f(9, h), 9, h);
    check("prerst_locked", {31'd0, locked}, 32'd1);
    check("prerst_x", {22'd0, x_out}, 32'd7);
    check("prerst_de", {31'd0, de_out}, 32'd1);
    async_reset();
    clear_fs();
    for (int h = 20; h < HT; h++) step(h < HS, 1'b0, de_f(9, h), 9, h);
    run_lines(10, VT, -1, -1);
    check("postrst_unlocked", {31'd0, locked}, 32'd0);
    for (int f = 0; f < 3; f++) run_lines(0, VT, -1, -1);
    check_lock_seq("relock");

    // One long line while locked
    terr0 = n_terr;
    run_lines(0, VT, 8, -1);
    check("longline_terr", n_terr - terr0, 32'd1);
    check("longline_err_count", {24'd0, err_count}, 32'd1);
    check("longline_unlocked", {31'd0, locked}, 32'd0);
    clear_fs();
    for (int f = 0; f < 3; f++) run_lines(0, VT, -1, -1);
    check_lock_seq("longline_relock");
    check("longline_terr_once", n_terr - terr0, 32'd1);

    // hsync missing for 2*H_TOTAL ticks while locked
    terr0 = n_terr;
    run_lines(0, VT, -1, 7);
    check("timeout_terr", n_terr - terr0, 32'd1);
    check("timeout_err_count", {24'd0, err_count}, 32'd2);
    check("timeout_unlocked", {31'd0, locked}, 32'd0);

    // Half-rate pix_en: same lock and coordinate behaviour
    async_reset();
    half = 1'b1;
    clear_fs();
    for (int f = 0; f < 3; f++) run_lines(0, VT, -1, -1);
    check_lock_seq("half");
    tab_en = 1'b1; tab_hits = 0;
    run_lines(0, VT, -1, -1);
    tab_en = 1'b0;
    check("half_vec_hits", tab_hits, NV);
    check("half_err_count", {24'd0, err_count}, 32'd0);

    // Error burst: each vsync+hsync edge enters VERIFY, the 1-tick hsync trips the width check
    async_reset();
    terr0 = n_terr;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, 1'b0, -1, -1);
      step(1'b0, 1'b0, 1'b0, -1, -1);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, -1, -1);
    check("burst100_err_count", {24'd0, err_count}, 32'd100);
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'b1, 1'b0, -1, -1);
      step(1'b0, 1'b0, 1'b0, -1, -1);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, -1, -1);
    check("burst_err_count_sat", {24'd0, err_count}, 32'd255);
    check("burst_terr_pulses", n_terr - terr0, 32'd300);
    check("burst_unlocked", {31'd0, locked}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
